// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the sized data memory
package dmem_pkg;

   typedef enum logic [1:0] {
      BYTE    = 2'b00,
      HALF    = 2'b01,
      WORD    = 2'b10,
      ILLEGAL = 2'b11
   } mem_size_e;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } dmem_state_e;

   // Natural alignment: halves on even bytes, words on multiples of four.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         BYTE:    ok = 1'b1;
         HALF:    ok = (addr_lo[0] == 1'b0);
         WORD:    ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and extension for loads
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] write_data,
   input  logic [31:0] load_word,
   input  logic        load_unsigned,
   output logic [3:0]  byte_en,
   output logic [31:0] write_lanes,
   output logic [31:0] load_result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: replicate the right-justified data into every lane it may land in.
   always_comb begin
      byte_en     = 4'b0000;
      write_lanes = write_data;
      case (size)
         BYTE: begin
            byte_en     = 4'b0001 << addr_lo;
            write_lanes = {4{write_data[7:0]}};
         end
         HALF: begin
            byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
            write_lanes = {2{write_data[15:0]}};
         end
         WORD: begin
            byte_en     = 4'b1111;
            write_lanes = write_data;
         end
         default: begin
            byte_en     = 4'b0000;
            write_lanes = write_data;
         end
      endcase
   end

   // Load side: pick the addressed lane(s) and extend to a full word.
   always_comb begin
      byte_sel    = load_word[{addr_lo, 3'b000} +: 8];
      half_sel    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
      load_result = load_word;
      case (size)
         BYTE:    load_result = load_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         HALF:    load_result = load_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_result = load_word;
      endcase
   end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed MEM-stage data memory with clear sweep
module data_memory_sized
   import dmem_pkg::*;
#(
   parameter int DEPTH          = 256,
   parameter int ADDR_WIDTH     = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            size,
   input  logic                  load_unsigned,
   output logic [31:0]           read_data,
   output logic                  read_valid,
   output logic                  misaligned,
   output logic                  ready
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [31:0]      mem [DEPTH];
   dmem_state_e      state;
   logic [IDX_W-1:0] clr_cnt;

   logic [IDX_W-1:0] idx;
   logic [1:0]       addr_lo;
   logic             aligned;
   logic             req;
   logic             do_write;
   logic             do_read;
   logic [3:0]       byte_en;
   logic [31:0]      write_lanes;
   logic [31:0]      stored;
   logic [31:0]      merged;
   logic [31:0]      load_result;
   logic             unused_addr_bits;

   // Upper address bits are deliberately ignored so the space wraps.
   assign unused_addr_bits = ^address[ADDR_WIDTH-1:IDX_W+2];

   assign idx      = address[IDX_W+1:2];
   assign addr_lo  = address[1:0];
   assign aligned  = is_aligned(size, addr_lo);
   // ready is only high in READY, so it alone gates acceptance.
   assign req      = ready && (mem_read || mem_write);
   assign do_write = req && mem_write && aligned;
   assign do_read  = req && mem_read && aligned;
   assign stored   = mem[idx];

   dmem_lane_align u_lane_align (
      .size          (size),
      .addr_lo       (addr_lo),
      .write_data    (write_data),
      .load_word     (merged),
      .load_unsigned (load_unsigned),
      .byte_en       (byte_en),
      .write_lanes   (write_lanes),
      .load_result   (load_result)
   );

   // Write-first merge: the word a same-cycle load sees is the word being stored.
   always_comb begin
      merged = stored;
      for (int i = 0; i < 4; i++) begin
         if (do_write && byte_en[i]) begin
            merged[8*i +: 8] = write_lanes[8*i +: 8];
         end
      end
   end

   // Array update: clear sweep during INIT, merged store word in READY.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            mem[clr_cnt] <= 32'h0;
         end else if (do_write) begin
            mem[idx] <= merged;
         end
      end
   end

   // FSM, clear counter and registered response strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= (CLEAR_ON_RESET != 0) ? INIT : READY;
         clr_cnt    <= '0;
         ready      <= 1'b0;
         read_data  <= 32'h0;
         read_valid <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         read_valid <= do_read;
         misaligned <= req && !aligned;
         if (do_read) begin
            read_data <= load_result;
         end
         if (state == INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
               state <= READY;
               ready <= 1'b1;
            end
         end else begin
            ready <= 1'b1;
         end
      end
   end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised, byte-addressed data memory for the processor's MEM stage, successor to the fixed word-only data memory. It adds byte, halfword and word loads and stores, sign or zero extension on loads, a registered read port with a valid strobe, misalignment detection, and a hardware clear sequence after reset. It sits between the ALU address output and the write-back mux.

## Interface
- `DEPTH`, 256: number of 32-bit words. Must be a power of two and at least 4.
- `ADDR_WIDTH`, 32: width of the byte address input.
- `CLEAR_ON_RESET`, 1: if 1, run the INIT sweep after reset to zero the array. If 0, go directly to READY.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, ADDR_WIDTH: byte address.
- `write_data`, in, 32: store data, right-justified.
- `mem_read`, in, 1: load request.
- `mem_write`, in, 1: store request.
- `size`, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `load_unsigned`, in, 1: 1 = zero-extend loads, 0 = sign-extend loads.
- `read_data`, out, 32: extended load result.
- `read_valid`, out, 1: one-cycle strobe marking `read_data` valid.
- `misaligned`, out, 1: one-cycle strobe flagging a rejected access.
- `ready`, out, 1: high when the block accepts requests.

## Operation
- **Word index.** Index = `address[$clog2(DEPTH)+1:2]`. Higher address bits are ignored, so the address space wraps modulo DEPTH*4.
- **Alignment rule.**
  - Half accesses require `address[0]`=0.
  - Word accesses require `address[1:0]`=0.
  - `size`=11 is always misaligned.
  - A misaligned access is fully suppressed: no array write and no `read_valid`. `misaligned` pulses instead.
- **Stores.**
  - Byte: `write_data[7:0]` is written to lane `address[1:0]`.
  - Half: `write_data[15:0]` is written to lanes {`address[1]`*2+1, `address[1]`*2}.
  - Word: all four lanes are written.
  - Unselected lanes are preserved.
- **Loads.** Extract the selected byte or half from the stored word, then extend it to 32 bits according to `load_unsigned`. `load_unsigned` is ignored for word loads.
- **Read and write in the same cycle, same word index.** The read returns the post-write word (write-first).
- **FSM states.**
  - INIT: `ready`=0. A clear counter walks index 0..DEPTH-1, writing 0 one word per cycle. All requests are ignored, and no strobes are produced.
  - READY: normal operation.
- **FSM transitions.**
  - `reset` → INIT with counter=0 when `CLEAR_ON_RESET`=1, otherwise → READY.
  - INIT → READY in the cycle after the counter writes index DEPTH-1.
  - Assertion of `reset` in any state, including mid-INIT, restarts the sequence from counter 0.
- **Reset values.** `read_data`=0, `read_valid`=0, `misaligned`=0, `ready`=0. `ready` is 1 on the first post-reset cycle if `CLEAR_ON_RESET`=0. When `CLEAR_ON_RESET`=0, array contents are not affected by reset.

## Timing
- **Store.** Committed at the rising edge where `ready`, `mem_write` and the alignment check are all true.
- **Load latency.** One cycle. A request sampled at edge N gives `read_data` and `read_valid` valid after edge N, for exactly one cycle.
- **Holding outputs.** `read_data` holds its last value when `read_valid`=0.
- **`misaligned` strobe.** Registered. It is asserted the cycle after the offending request, and only if `mem_read` or `mem_write` was high.
- **Back-to-back loads.** Sustained at one per cycle. There is no bubble between loads, or between a load and a store.
- **`ready` deassertion.** `ready` falls on the edge that samples `reset`=1.
- **Sweep length.** INIT lasts exactly DEPTH cycles.

## Structure
- **Package `dmem_pkg`.**
  - `mem_size_e` enum: BYTE, HALF, WORD, ILLEGAL.
  - `dmem_state_e` enum: INIT, READY.
  - Function `is_aligned(size, addr_lo)`.
- **Sub-module `dmem_lane_align`.** Purely combinational.
  - Store side: byte-enable generation and lane replication of `write_data`.
  - Load side: lane extraction and sign or zero extension.
- **Top level.** Holds the array, the FSM, the clear counter, the write-first bypass and the output registers.

## Test plan
- **Word store and load.** Reset, wait 256 cycles (DEPTH=256) until `ready`=1. Store word 0xABCDEFFA at 0x50, then load word at 0x50. Expect `read_data`=0xABCDEFFA with `read_valid` one cycle after the load.
- **Sub-word store and extension.** Continuing from the previous scenario, store byte 0x80 at 0x53.
  - Signed byte load at 0x53 → 0xFFFFFF80.
  - Unsigned byte load → 0x00000080.
  - Word load at 0x50 → 0x80CDEFFA.
  - Signed half load at 0x52 → 0xFFFF80CD.
- **Misalignment.** Half store 0x1234 at 0x51 → `misaligned`=1 for one cycle, no `read_valid`. A word load at 0x50 still returns 0x80CDEFFA. A `size`=11 request also flags `misaligned`.
- **Same-cycle read/write and wrap-around.**
  - `mem_write` and `mem_read` in the same cycle at 0x14 with 0xDEADBEEF → `read_data`=0xDEADBEEF the next cycle.
  - Load word at 0x414 → 0xDEADBEEF (wraps to 0x14).
- **Reset mid-INIT.**
  - Assert `reset` at cycle 100 of INIT. `ready` must stay 0 for a full 256 cycles after the release.
  - Requests issued during INIT produce no strobes.
  - Afterwards, a load of 0x14 returns 0.
- **Back-to-back loads.** Loads at 0x00, 0x04 and 0x08 on consecutive cycles give three consecutive `read_valid` pulses with the correct data in order.
